// File: rtl/riscv_dram_ctrl.sv
// DRAM transaction sequencer for data-cache writeback/fill requests.
// Optional RISCV_DRAM_CTRL_STATS_EN adds fill/writeback counters.
module riscv_dram_ctrl #(
  parameter int DATA_WIDTH  = 128,
  parameter int S_ADDR      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_wb,
  input  logic                  req_fill,
  input  logic [S_ADDR-1:0]     wb_addr,
  input  logic [S_ADDR-1:0]     fill_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [S_ADDR-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef RISCV_DRAM_CTRL_STATS_EN
  ,
  output logic [15:0]           fill_cnt,
  output logic [15:0]           wb_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WB, S_RD, S_CAP, S_DONE
  } state_t;

  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES);

  state_t state, state_n;
  logic [3:0] wcnt, wcnt_n;
  logic [S_ADDR-1:0] addr_n, lat_faddr;
  logic [DATA_WIDTH-1:0] wdata_n;
  logic lat_fill, accept, phase_end;

  assign accept    = (state == S_IDLE) && req_valid;
  assign phase_end = (wcnt == WLAST);

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;
    unique case (state)
      S_IDLE: begin
        if (req_valid) begin
          wcnt_n = '0;
          if (req_wb) begin
            state_n = S_WB;
            addr_n  = wb_addr;
            wdata_n = wb_data;
          end else if (req_fill) begin
            state_n = S_RD;
            addr_n  = fill_addr;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_WB: begin
        if (phase_end) begin
          wcnt_n = '0;
          if (lat_fill) begin
            state_n = S_RD;
            addr_n  = lat_faddr;
          end else begin
            state_n = S_DONE;
          end
        end else begin
          wcnt_n = wcnt + 4'd1;
        end
      end
      S_RD: begin
        if (phase_end) begin
          wcnt_n  = '0;
          state_n = S_CAP;
        end else begin
          wcnt_n = wcnt + 4'd1;
        end
      end
      S_CAP:   state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are flopped from next-state so they stay glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      mem_wren  <= 1'b0;
      mem_rden  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      fill_data <= '0;
      lat_fill  <= 1'b0;
      lat_faddr <= '0;
    end else begin
      state     <= state_n;
      wcnt      <= wcnt_n;
      ready     <= (state_n == S_IDLE);
      done      <= (state_n == S_DONE);
      mem_wren  <= (state_n == S_WB);
      mem_rden  <= (state_n == S_RD);
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      if (accept) begin
        lat_fill  <= req_fill;
        lat_faddr <= fill_addr;
      end
      if (state == S_CAP)
        fill_data <= mem_rdata;
    end
  end

`ifdef RISCV_DRAM_CTRL_STATS_EN
  logic lat_wb, inc_fill, inc_wb;

  // IDLE->DONE is the empty request, so it never counts.
  assign inc_fill = (state == S_CAP);
  assign inc_wb   = lat_wb && (state_n == S_DONE) &&
                    (state == S_CAP || state == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_wb   <= 1'b0;
      fill_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (accept)
        lat_wb <= req_wb;
      if (inc_fill && fill_cnt != 16'hFFFF)
        fill_cnt <= fill_cnt + 16'd1;
      if (inc_wb && wb_cnt != 16'hFFFF)
        wb_cnt <= wb_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_dram_ctrl.sv
// Directed bench for riscv_dram_ctrl: W=0 and W=2 instances,
// each with its own behavioural DRAM.
module tb_riscv_dram_ctrl;

  localparam logic [127:0] DA5 = {16{8'hA5}};
  localparam logic [127:0] D1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2  = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D3  = 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0;

  logic clk, rst_n;
  logic req_valid0, req_valid2, req_wb, req_fill;
  logic [9:0] wb_addr, fill_addr;
  logic [127:0] wb_data;

  logic ready0, done0, wren0, rden0;
  logic ready2, done2, wren2, rden2;
  logic [9:0] addr0, addr2;
  logic [127:0] fdata0, fdata2, wdata0, wdata2, rdata0, rdata2;
`ifdef RISCV_DRAM_CTRL_STATS_EN
  logic [15:0] fill_cnt0, wb_cnt0, fill_cnt2, wb_cnt2;
`endif

  logic [127:0] mem0 [0:1023];
  logic [127:0] mem2 [0:1023];
  logic pre_we0, pre_we2;
  logic [9:0] pre_addr;
  logic [127:0] pre_data;

  int total = 0;
  int bad = 0;

  riscv_dram_ctrl #(.DATA_WIDTH(128), .S_ADDR(10), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0),
    .req_wb(req_wb), .req_fill(req_fill),
    .wb_addr(wb_addr), .fill_addr(fill_addr), .wb_data(wb_data),
    .ready(ready0), .done(done0), .fill_data(fdata0),
    .mem_wren(wren0), .mem_rden(rden0), .mem_addr(addr0),
    .mem_wdata(wdata0), .mem_rdata(rdata0)
`ifdef RISCV_DRAM_CTRL_STATS_EN
    , .fill_cnt(fill_cnt0), .wb_cnt(wb_cnt0)
`endif
  );

  riscv_dram_ctrl #(.DATA_WIDTH(128), .S_ADDR(10), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid2),
    .req_wb(req_wb), .req_fill(req_fill),
    .wb_addr(wb_addr), .fill_addr(fill_addr), .wb_data(wb_data),
    .ready(ready2), .done(done2), .fill_data(fdata2),
    .mem_wren(wren2), .mem_rden(rden2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_rdata(rdata2)
`ifdef RISCV_DRAM_CTRL_STATS_EN
    , .fill_cnt(fill_cnt2), .wb_cnt(wb_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we0) mem0[pre_addr] <= pre_data;
    if (wren0) mem0[addr0] <= wdata0;
    if (rden0) rdata0 <= mem0[addr0];
  end

  always @(posedge clk) begin
    if (pre_we2) mem2[pre_addr] <= pre_data;
    if (wren2) mem2[addr2] <= wdata2;
    if (rden2) rdata2 <= mem2[addr2];
  end

  bit sel;
  logic s_ready, s_done, s_wren, s_rden;
  logic [9:0] s_addr;
  logic [127:0] s_wdata;
  assign s_ready = sel ? ready2 : ready0;
  assign s_done  = sel ? done2  : done0;
  assign s_wren  = sel ? wren2  : wren0;
  assign s_rden  = sel ? rden2  : rden0;
  assign s_addr  = sel ? addr2  : addr0;
  assign s_wdata = sel ? wdata2 : wdata0;

  int r_wr, r_rd, r_done, r_done_at, r_ovl, r_last_wr, r_first_rd;
  logic [9:0] r_wr_addr, r_rd_addr;
  logic [127:0] r_wr_data;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input bit s, input logic [9:0] a,
                         input logic [127:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    if (s) pre_we2 = 1'b1;
    else pre_we0 = 1'b1;
    @(posedge clk);
    #1;
    pre_we0 = 1'b0;
    pre_we2 = 1'b0;
  endtask

  task automatic start(input bit s, input bit wb, input bit fl,
                       input logic [9:0] wa, input logic [9:0] fa,
                       input logic [127:0] wd, input bit hold);
    sel = s;
    @(negedge clk);
    req_wb    = wb;
    req_fill  = fl;
    wb_addr   = wa;
    fill_addr = fa;
    wb_data   = wd;
    chk("pre_ready", s_ready, 1'b1);
    if (s) req_valid2 = 1'b1;
    else req_valid0 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid0 = 1'b0;
      req_valid2 = 1'b0;
    end
  endtask

  task automatic run(input bit s, input bit wb, input bit fl,
                     input logic [9:0] wa, input logic [9:0] fa,
                     input logic [127:0] wd, input bit hold,
                     input int ncyc);
    start(s, wb, fl, wa, fa, wd, hold);
    r_wr = 0; r_rd = 0; r_done = 0; r_ovl = 0;
    r_done_at = -1; r_last_wr = -1; r_first_rd = -1;
    r_wr_addr = '0; r_rd_addr = '0; r_wr_data = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (s_wren) begin
        r_wr++;
        r_last_wr = c;
        r_wr_addr = s_addr;
        r_wr_data = s_wdata;
      end
      if (s_rden) begin
        r_rd++;
        if (r_first_rd < 0) r_first_rd = c;
        r_rd_addr = s_addr;
      end
      if (s_wren && s_rden) r_ovl++;
      if (s_done) begin
        r_done++;
        if (r_done_at < 0) r_done_at = c;
        req_valid0 = 1'b0;
        req_valid2 = 1'b0;
      end
    end
    req_valid0 = 1'b0;
    req_valid2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid0 = 1'b0; req_valid2 = 1'b0;
    req_wb = 1'b0; req_fill = 1'b0;
    wb_addr = '0; fill_addr = '0; wb_data = '0;
    pre_we0 = 1'b0; pre_we2 = 1'b0;
    pre_addr = '0; pre_data = '0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ready", ready0, 1'b1);
      chk("idle_done", done0, 1'b0);
      chk("idle_wren", wren0, 1'b0);
      chk("idle_rden", rden0, 1'b0);
      chk("idle_fdata", fdata0, '0);
    end
    chk("idle_addr", addr0, '0);
    chk("idle_ready2", ready2, 1'b1);

    preload(1'b0, 10'h005, DA5);
    run(1'b0, 1'b0, 1'b1, 10'h000, 10'h005, '0, 1'b0, 8);
    chk("f0_rd_cnt", 128'(r_rd), 128'd1);
    chk("f0_rd_addr", r_rd_addr, 10'h005);
    chk("f0_wr_cnt", 128'(r_wr), 128'd0);
    chk("f0_done_at", 128'(r_done_at), 128'd3);
    chk("f0_done_cnt", 128'(r_done), 128'd1);
    chk("f0_fdata", fdata0, DA5);

    run(1'b0, 1'b1, 1'b0, 10'h033, 10'h3FF, D1, 1'b0, 8);
    chk("w0_wr_cnt", 128'(r_wr), 128'd1);
    chk("w0_wr_addr", r_wr_addr, 10'h033);
    chk("w0_wr_data", r_wr_data, D1);
    chk("w0_rd_cnt", 128'(r_rd), 128'd0);
    chk("w0_done_at", 128'(r_done_at), 128'd2);
    chk("w0_fdata_kept", fdata0, DA5);

    run(1'b0, 1'b0, 1'b0, 10'h077, 10'h077, D2, 1'b0, 6);
    chk("n0_done_at", 128'(r_done_at), 128'd1);
    chk("n0_wr_cnt", 128'(r_wr), 128'd0);
    chk("n0_rd_cnt", 128'(r_rd), 128'd0);
    chk("n0_fdata_kept", fdata0, DA5);

    run(1'b0, 1'b0, 1'b1, 10'h000, 10'h033, '0, 1'b1, 10);
    chk("h0_done_cnt", 128'(r_done), 128'd1);
    chk("h0_done_at", 128'(r_done_at), 128'd3);
    chk("h0_rd_cnt", 128'(r_rd), 128'd1);
    chk("h0_fdata", fdata0, D1);

    run(1'b0, 1'b1, 1'b1, 10'h040, 10'h005, D2, 1'b0, 8);
    chk("b0_done_at", 128'(r_done_at), 128'd4);
    chk("b0_wr_cnt", 128'(r_wr), 128'd1);
    chk("b0_rd_cnt", 128'(r_rd), 128'd1);
    chk("b0_ovl", 128'(r_ovl), 128'd0);
    chk("b0_rd_addr", r_rd_addr, 10'h005);
    chk("b0_fdata", fdata0, DA5);

`ifdef RISCV_DRAM_CTRL_STATS_EN
    chk("st_fill_cnt", fill_cnt0, 16'd3);
    chk("st_wb_cnt", wb_cnt0, 16'd2);
`endif

    run(1'b1, 1'b1, 1'b1, 10'h010, 10'h010, D3, 1'b0, 12);
    chk("b2_wr_cnt", 128'(r_wr), 128'd3);
    chk("b2_rd_cnt", 128'(r_rd), 128'd3);
    chk("b2_last_wr", 128'(r_last_wr), 128'd3);
    chk("b2_first_rd", 128'(r_first_rd), 128'd4);
    chk("b2_done_at", 128'(r_done_at), 128'd8);
    chk("b2_ovl", 128'(r_ovl), 128'd0);
    chk("b2_fdata", fdata2, D3);

    start(1'b1, 1'b1, 1'b0, 10'h050, 10'h000, D2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rw_wren_before", wren2, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rw_wren", wren2, 1'b0);
    chk("rw_rden", rden2, 1'b0);
    chk("rw_ready", ready2, 1'b1);
    chk("rw_done", done2, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run(1'b1, 1'b0, 1'b1, 10'h000, 10'h010, '0, 1'b0, 10);
    chk("r2_done_at", 128'(r_done_at), 128'd5);
    chk("r2_rd_cnt", 128'(r_rd), 128'd3);
    chk("r2_fdata", fdata2, D3);

`ifdef RISCV_DRAM_CTRL_STATS_EN
    @(negedge clk);
    force u0.fill_cnt = 16'hFFFF;
    @(negedge clk);
    release u0.fill_cnt;
    run(1'b0, 1'b0, 1'b1, 10'h000, 10'h005, '0, 1'b0, 8);
    chk("st_fill_sat", fill_cnt0, 16'hFFFF);
    chk("st_wb_after_rst", wb_cnt0, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_dram_ctrl.md
# riscv_dram_ctrl

Memory-side transaction controller that drives the block-wide data DRAM on behalf of the data cache. It accepts one cache miss request at a time: an optional dirty-block writeback, an optional block fill, or both, with writeback first. It sequences the DRAM write/read strobes, captures the registered read data, and returns a one-cycle completion pulse with the filled block. It sits between the cache FSM and the DRAM data array, on the initiator side of that array's `wren`/`rden`/`addr`/`data_in`/`data_out` port.

## Interface
- `DATA_WIDTH`, 128, block width in bits; equals the DRAM word.
- `S_ADDR`, 10, block address width; equals the DRAM `addr` width.
- `WAIT_CYCLES`, 0, extra cycles each DRAM access phase is held; legal range 0..15.

- `clk` input 1: single clock. All state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: request strobe. Sampled only while `ready`=1.
- `req_wb` input 1: request includes a writeback of `wb_data` to `wb_addr`.
- `req_fill` input 1: request includes a fill from `fill_addr`.
- `wb_addr` input S_ADDR: writeback block address.
- `fill_addr` input S_ADDR: fill block address.
- `wb_data` input DATA_WIDTH: writeback block.
- `ready` output 1: controller is idle and can accept a request.
- `done` output 1: one-cycle completion pulse.
- `fill_data` output DATA_WIDTH: last filled block. Valid from `done` until the next fill completes.
- `mem_wren` output 1: DRAM write enable.
- `mem_rden` output 1: DRAM read enable.
- `mem_addr` output S_ADDR: DRAM block address.
- `mem_wdata` output DATA_WIDTH: DRAM write data.
- `mem_rdata` input DATA_WIDTH: DRAM read data. The DRAM registers it one edge after `mem_addr` is sampled.

## Operation
- States: IDLE, WB, RD, CAP, DONE.
- IDLE:
  - `ready`=1.
  - On `req_valid`, latch `req_wb`, `req_fill`, both addresses and `wb_data` into internal registers. Inputs are don't-care after acceptance.
  - Next state is WB if `req_wb`, else RD if `req_fill`, else DONE.
- WB:
  - `mem_wren`=1, `mem_rden`=0, `mem_addr`=latched `wb_addr`, `mem_wdata`=latched data.
  - Held for WAIT_CYCLES+1 cycles, counted by a wait counter.
  - Then go to RD if the fill is latched, else DONE.
- RD:
  - `mem_rden`=1, `mem_wren`=0, `mem_addr`=latched `fill_addr`.
  - Held for WAIT_CYCLES+1 cycles, then go to CAP.
- CAP:
  - Strobes low; `mem_addr` stays held.
  - On the exit edge, `fill_data` <= `mem_rdata`. Then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `mem_wren` and `mem_rden` are never both 1, because the DRAM suppresses the write when both are asserted.
- A request with neither `req_wb` nor `req_fill` set goes straight to DONE: no DRAM access, and `fill_data` is unchanged.
- `req_valid` outside IDLE is ignored. There is no queuing.
- The wait counter is 4 bits, clears on every phase entry, and never wraps within a phase.

## Timing
- Reset values (asynchronous, on `rst_n` low):
  - state=IDLE, `ready`=1, `done`=0.
  - `mem_wren`=0, `mem_rden`=0.
  - `mem_addr`=0, `mem_wdata`=0, `fill_data`=0, wait counter=0.
- Reset asserted mid-transaction:
  - Strobes drop immediately, without waiting for an edge.
  - A partially held write may or may not have landed. The cache must reissue the request.
- All outputs are registered; none is combinational from the inputs.
- `done` rises N cycles after the acceptance edge (W = WAIT_CYCLES):
  - writeback only: N = W+2
  - fill only: N = W+3
  - writeback plus fill: N = 2W+4
  - neither: N = 1
- `ready` is 0 from the cycle after acceptance through the DONE cycle. It returns to 1 in the cycle after `done`, so the earliest back-to-back accept is the edge ending that cycle.

## Configuration
- `RISCV_DRAM_CTRL_STATS_EN` defined:
  - Adds outputs `fill_cnt` and `wb_cnt`, both 16 bits.
  - Each counter increments by one on the edge entering DONE, once per completed fill or writeback.
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then idle 5 cycles: `ready`=1, `done`=0, both strobes 0, `fill_data`=0 throughout.
- W=0, fill only from `fill_addr`=0x005 with DRAM preloaded 0xA5…A5: `mem_rden`=1 for exactly 1 cycle with `mem_addr`=0x005, `done` 3 cycles after accept, `fill_data`=0xA5…A5.
- W=2, writeback plus fill: `wb_addr`=0x010, `wb_data`=0x1234…, `fill_addr`=0x010. Required: `mem_wren` high for 3 cycles, then `mem_rden` high for 3 cycles, `done` at cycle 8, `fill_data`=0x1234…, and the strobes never overlap.
- `req_valid` pulsed every cycle during a transaction: exactly one transaction runs, with exactly one `done`.
- `rst_n` dropped during the WB phase: strobes are 0 within the same cycle (before the next edge), state is IDLE, and the next request completes normally.
- With `RISCV_DRAM_CTRL_STATS_EN` defined: 3 fills and 2 writebacks give `fill_cnt`=3 and `wb_cnt`=2. With `fill_cnt` preset to 0xFFFF via forced state, one more fill leaves it at 0xFFFF.
